mul: RTL
========

MUL -- requirements
Module: mul

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port ld, input, 1 bit: when 1, load the operands; when 0, run the multiply.
REQ-005 The block SHALL have port a, input, W bits: the multiplicand.
REQ-006 The block SHALL have port b, input, W bits: the multiplier.
REQ-007 The block SHALL have port rp, output, 2W bits: the partial product accumulator, which holds the product when done.
REQ-008 The block SHALL have port rm, output, 2W bits: the shifted multiplicand register.
REQ-009 The block SHALL have port rq, output, W bits: the remaining multiplier bits register.
REQ-010 The block SHALL have port cnt, output, clog2(W+1) bits: the count of completed iterations.
REQ-011 The block SHALL have port busy, output, 1 bit: high while the state is RUN.
REQ-012 The block SHALL have port done, output, 1 bit: high while the state is DONE.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 On any rising edge with ld=1, in any state, the block SHALL load: rp<=0, rm<=a extended to 2W bits, rq<=b, cnt<=0, state<=RUN.
REQ-015 ld SHALL take priority over all other behaviour, including in the middle of a run.
REQ-016 On each rising edge in RUN with ld=0, the block SHALL perform one iteration: if rq[0]=1 then rp<=rp+rm modulo 2^(2W); rm<=rm<<1; rq<=rq>>1 with zero fill; cnt<=cnt+1.
REQ-017 On the iteration where cnt=W-1 before the edge, the state SHALL become DONE.
REQ-018 Latency SHALL be fixed: done=1 after exactly W rising edges with ld=0 that follow the last edge with ld=1.
REQ-019 There SHALL be no early termination when rq becomes 0, including when b=0.
REQ-020 In DONE with ld=0, all registers SHALL hold, and done SHALL stay 1 until the next load or reset.
REQ-021 In IDLE with ld=0, all registers SHALL hold.
REQ-022 busy and done SHALL be decoded combinationally from the state register only, and SHALL never be 1 at the same time.
REQ-023 If ld is held at 1 for any number of cycles, the block SHALL re-load every edge, perform no iteration, and keep busy=1, done=0, cnt=0.
REQ-024 If a or b changes while ld=0, it SHALL have no effect on the run in progress or on a held result.

Reset
REQ-025 When rst=0, the block SHALL asynchronously force state=IDLE and rp=0, rm=0, rq=0, cnt=0, busy=0, done=0, regardless of clk or ld.
REQ-026 Reset asserted mid-run SHALL abandon the operation.
REQ-027 After reset is released, the block SHALL stay in IDLE until the first edge with ld=1.
REQ-028 No output SHALL be X after reset.

Configuration
REQ-029 With macro MUL_SIGNED_EN defined, a and b SHALL be treated as two's complement: rm loads a sign-extended to 2W bits, and the final iteration (cnt=W-1) subtracts rm instead of adding it when rq[0]=1, so that rp holds the signed 2W-bit product.
REQ-030 With MUL_SIGNED_EN not defined, a and b SHALL be unsigned: rm loads a zero-extended, and every iteration adds; the iteration count and latency SHALL be identical in both builds.

Verification (W=4)
REQ-031 Reset mid-run: rst=0 after 2 iterations -> rp, rm, rq, cnt, busy and done all 0 immediately, without waiting for a clock edge; state IDLE; registers hold with ld=0.
REQ-032 Unsigned maximum: a=4'hF, b=4'hF, one ld=1 edge, then 4 edges with ld=0 -> rp=8'hE1, cnt=4, done=1, busy=0; rp unchanged after 10 further edges.
REQ-033 Zero operand: a=4'h9, b=4'h0 -> done only after the 4th ld=0 edge, rp=8'h00.
REQ-034 Reload mid-run: a=3, b=5, 2 iterations, then ld=1 with a=6, b=7, then 4 ld=0 edges -> rp=8'h2A, and done was never 1 before the final edge.
REQ-035 Held load: ld=1 for 10 edges with a=5, b=5 -> rp=0, cnt=0, busy=1, done=0 throughout.
REQ-036 Sign mode: a=4'hF, b=4'h8 -> rp=8'h08 with MUL_SIGNED_EN defined; rp=8'h78 without it.

Source files
------------

// File: rtl/mul.sv
// rtl/mul.sv - shift-and-add sequential multiplier, fixed W-cycle latency (MUL_SIGNED_EN selects two's complement operands)
module mul #(
   parameter int W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ld,
   input  logic [W-1:0]             a,
   input  logic [W-1:0]             b,
   output logic [2*W-1:0]           rp,
   output logic [2*W-1:0]           rm,
   output logic [W-1:0]             rq,
   output logic [$clog2(W+1)-1:0]   cnt,
   output logic                     busy,
   output logic                     done
);

   localparam int CW = $clog2(W+1);
   localparam logic [CW-1:0] LAST_CNT = CW'(W-1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2*W-1:0]    r_rp;
   logic [2*W-1:0]    r_rm;
   logic [W-1:0]      r_rq;
   logic [CW-1:0]     r_cnt;

   logic              w_last;
   logic [2*W-1:0]    w_a_ext;
   logic [2*W-1:0]    w_addend;
   logic [2*W-1:0]    w_rp_nxt;

   // The final iteration is the one that retires the last multiplier bit
   assign w_last = (r_cnt == LAST_CNT);

`ifdef MUL_SIGNED_EN
   // Signed: the multiplier's top bit carries weight -2^(W-1), so the
   // last partial product is subtracted rather than added
   assign w_a_ext  = {{W{a[W-1]}}, a};
   assign w_addend = w_last ? (~r_rm + {{(2*W-1){1'b0}}, 1'b1}) : r_rm;
`else
   assign w_a_ext  = {{W{1'b0}}, a};
   assign w_addend = r_rm;
`endif

   // Accumulate the current partial product only when the retiring bit is set
   assign w_rp_nxt = r_rq[0] ? (r_rp + w_addend) : r_rp;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: a load restarts from any state, RUN ends after W iterations
   always_comb begin
      w_state_nxt = r_state;
      if (ld) begin
         w_state_nxt = RUN;
      end else begin
         case (r_state)
            IDLE:    w_state_nxt = IDLE;
            RUN:     w_state_nxt = w_last ? DONE : RUN;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Datapath: load on ld, one shift-add step per RUN cycle, hold otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rp  <= '0;
         r_rm  <= '0;
         r_rq  <= '0;
         r_cnt <= '0;
      end else if (ld) begin
         r_rp  <= '0;
         r_rm  <= w_a_ext;
         r_rq  <= b;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_rp  <= w_rp_nxt;
         r_rm  <= {r_rm[2*W-2:0], 1'b0};
         r_rq  <= {1'b0, r_rq[W-1:1]};
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign rp   = r_rp;
   assign rm   = r_rm;
   assign rq   = r_rq;
   assign cnt  = r_cnt;
   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);

endmodule
